modexp_io_buffer: RTL

- Device-side endpoint of the word-serial ModExp host interface.
- Deserializes the 4096-bit operands M, E, N, R and T from 64-bit bus words into wide registers and hands them to the exponentiation core.
- Sequences the core start on the host's compute strobe.
- Serializes the 4096-bit core result back to the host one 64-bit word per cycle.

---
 rtl/modexp_io_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/modexp_io_buffer.sv
// Word-serial host endpoint for the ModExp core: assembles wide operands from bus
// words, issues the core start pulse, and streams the latched result back out.
module modexp_io_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 64,
  parameter int IDX_W      = 7
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_input,
  input  logic [DATA_WIDTH-1:0]            m_buf,
  input  logic [DATA_WIDTH-1:0]            e_buf,
  input  logic [DATA_WIDTH-1:0]            n_buf,
  input  logic [DATA_WIDTH-1:0]            r_buf,
  input  logic [DATA_WIDTH-1:0]            t_buf,
  input  logic                             start_compute,
  input  logic                             get_result,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  m_op,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  e_op,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  n_op,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  r_op,
  output logic [DATA_WIDTH*NUM_WORDS-1:0]  t_op,
  output logic                             operands_ready,
  output logic                             core_start,
  input  logic                             core_done,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  core_result,
  output logic [DATA_WIDTH-1:0]            res_out,
  output logic                             res_valid,
  output logic                             res_last,
  output logic [2:0]                       state
);

  localparam int OP_W  = DATA_WIDTH * NUM_WORDS;
  localparam int OFF_W = $clog2(OP_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READY = 3'd2,
    RUN   = 3'd3,
    HOLD  = 3'd4,
    SEND  = 3'd5
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [OP_W-1:0]   shadow;

  assign state = state_q;
  assign off   = OFF_W'(idx) * OFF_W'(DATA_WIDTH);

  // Result stream handshake: res_valid marks one word per cycle, res_last marks the
  // final word; there is no ready, so the host must accept every valid word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx            <= '0;
      m_op           <= '0;
      e_op           <= '0;
      n_op           <= '0;
      r_op           <= '0;
      t_op           <= '0;
      shadow         <= '0;
      res_out        <= '0;
      res_valid      <= 1'b0;
      res_last       <= 1'b0;
      core_start     <= 1'b0;
      operands_ready <= 1'b0;
    end else begin
      core_start <= 1'b0;
      res_valid  <= 1'b0;
      res_last   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_input) begin
            state_q <= LOAD;
            idx     <= '0;
          end
        end
        LOAD: begin
          m_op[off +: DATA_WIDTH] <= m_buf;
          e_op[off +: DATA_WIDTH] <= e_buf;
          n_op[off +: DATA_WIDTH] <= n_buf;
          r_op[off +: DATA_WIDTH] <= r_buf;
          t_op[off +: DATA_WIDTH] <= t_buf;
          if (idx == LAST_IDX) begin
            state_q        <= READY;
            idx            <= '0;
            operands_ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        READY: begin
          // A compute request takes priority over a reload request.
          if (start_compute) begin
            state_q        <= RUN;
            core_start     <= 1'b1;
            operands_ready <= 1'b0;
          end else if (start_input) begin
            state_q        <= LOAD;
            idx            <= '0;
            operands_ready <= 1'b0;
          end
        end
        RUN: begin
          if (core_done) begin
            shadow  <= core_result;
            idx     <= '0;
            state_q <= get_result ? SEND : HOLD;
          end
        end
        HOLD: begin
          if (get_result) begin
            state_q <= SEND;
            idx     <= '0;
          end
        end
        SEND: begin
          res_out   <= shadow[off +: DATA_WIDTH];
          res_valid <= 1'b1;
          if (idx == LAST_IDX) begin
            res_last <= 1'b1;
            idx      <= '0;
            state_q  <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idx     <= '0;
        end
      endcase
    end
  end

endmodule
